// File: rtl/teclado_scan.sv
// 4x4 keypad scanner: strobes columns, debounces the row readback and hands a
// 4-bit key code to the consumer over a valid/ack handshake.
module teclado_scan #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fila,
  output logic [3:0] columna,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       done,
  output logic       overrun
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_TARGET  = CW'(DEBOUNCE_SCANS);
  localparam bit            SINGLE_SCAN = (DEBOUNCE_SCANS == 1);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] RELEASE  = 2'd2;

  logic [3:0]    fila_meta_reg;
  logic [3:0]    frows_reg;
  logic [DW-1:0] divider_reg;
  logic          tick;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [3:0]    columna_reg, columna_next;
  logic [1:0]    row_idx_reg, row_idx_next;
  logic [1:0]    col_idx_reg, col_idx_next;
  logic          confirm;

  logic [3:0]    key_code_reg, key_code_next;
  logic          key_valid_reg, key_valid_next;
  logic          done_reg, done_next;
  logic          overrun_reg, overrun_next;

  logic          frows_onehot;
  logic [3:0]    row_mask;
  logic [3:0]    columna_rot;

  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // fila is asynchronous to clk; only the second flop's value is ever used.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fila_meta_reg <= 4'b0000;
      frows_reg     <= 4'b0000;
    end else begin
      fila_meta_reg <= fila;
      frows_reg     <= fila_meta_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divider_reg <= '0;
    end else if (divider_reg == DIV_LAST) begin
      divider_reg <= '0;
    end else begin
      divider_reg <= divider_reg + 1'b1;
    end
  end

  assign tick         = (divider_reg == DIV_LAST);
  assign frows_onehot = (frows_reg != 4'b0000) && ((frows_reg & (frows_reg - 4'd1)) == 4'b0000);
  assign row_mask     = 4'b0001 << row_idx_reg;
  assign columna_rot  = {columna_reg[2:0], columna_reg[3]};

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    columna_next = columna_reg;
    row_idx_next = row_idx_reg;
    col_idx_next = col_idx_reg;
    confirm      = 1'b0;
    if (tick) begin
      case (state_reg)
        SCAN: begin
          // Multiple rows high means ghosting: treat as no key and keep moving.
          if (frows_onehot) begin
            row_idx_next = enc4(frows_reg);
            col_idx_next = enc4(columna_reg);
            if (SINGLE_SCAN) begin
              confirm    = 1'b1;
              count_next = '0;
              state_next = RELEASE;
            end else begin
              count_next = CW'(1);
              state_next = DEBOUNCE;
            end
          end else begin
            columna_next = columna_rot;
          end
        end
        DEBOUNCE: begin
          if (frows_reg == row_mask) begin
            if (count_reg + 1'b1 == CNT_TARGET) begin
              confirm    = 1'b1;
              count_next = '0;
              state_next = RELEASE;
            end else begin
              count_next = count_reg + 1'b1;
            end
          end else begin
            count_next   = '0;
            state_next   = SCAN;
            columna_next = columna_rot;
          end
        end
        RELEASE: begin
          if (frows_reg == 4'b0000) begin
            if (count_reg + 1'b1 == CNT_TARGET) begin
              count_next   = '0;
              state_next   = SCAN;
              columna_next = columna_rot;
            end else begin
              count_next = count_reg + 1'b1;
            end
          end else begin
            count_next = '0;
          end
        end
        default: begin
          count_next = '0;
          state_next = SCAN;
        end
      endcase
    end
  end

  // A confirm wins over a plain ack: an ack in the confirm cycle frees the slot.
  always_comb begin
    key_code_next  = key_code_reg;
    key_valid_next = key_valid_reg;
    done_next      = 1'b0;
    overrun_next   = 1'b0;
    if (confirm) begin
      if (!key_valid_reg || key_ack) begin
        key_code_next  = {row_idx_next, col_idx_next};
        key_valid_next = 1'b1;
        done_next      = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (key_ack && key_valid_reg) begin
      key_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= SCAN;
      count_reg     <= '0;
      columna_reg   <= 4'b0001;
      row_idx_reg   <= 2'd0;
      col_idx_reg   <= 2'd0;
      key_code_reg  <= 4'h0;
      key_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      columna_reg   <= columna_next;
      row_idx_reg   <= row_idx_next;
      col_idx_reg   <= col_idx_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      done_reg      <= done_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign columna   = columna_reg;
  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign done      = done_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_teclado_scan.sv
// Directed bench for teclado_scan with SCAN_DIV=4, DEBOUNCE_SCANS=3: one vector
// per scan tick, plus hand-written bounce and async-reset sequences.
module tb_teclado_scan;
  localparam int SD = 4;
  localparam int DS = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] fila;
  logic [3:0] columna;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       done;
  logic       overrun;

  teclado_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .reset(reset), .fila(fila), .columna(columna),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] fila;
    logic       ack;
    logic [3:0] col;
    logic       kv;
    logic [3:0] code;
    logic       done;
    logic       ov;
  } vec_t;

  vec_t       vecs[$];
  int         checks = 0;
  int         errors = 0;
  int         cur_vec = 0;
  logic [3:0] exp_col;
  logic       exp_kv;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec %0d %s: got %h expected %h", cur_vec, name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] f, input logic a, input logic [3:0] c,
                     input logic kv, input logic [3:0] code, input logic d, input logic o);
    vec_t v;
    v.fila = f; v.ack = a; v.col = c; v.kv = kv; v.code = code; v.done = d; v.ov = o;
    vecs.push_back(v);
  endtask

  // Entered #1 after a tick edge; drives fila for one full dwell, acks on the next tick edge.
  task automatic run_vec(input vec_t v);
    fila    = v.fila;
    key_ack = 1'b0;
    for (int e = 1; e < SD; e++) begin
      @(posedge clk); #1;
      chk("col_hold", columna, exp_col);
      chk("kv_hold", {3'b0, key_valid}, {3'b0, exp_kv});
      chk("pulse_idle", {2'b0, done, overrun}, 4'h0);
    end
    key_ack = v.ack;
    @(posedge clk); #1;
    chk("columna", columna, v.col);
    chk("key_valid", {3'b0, key_valid}, {3'b0, v.kv});
    chk("key_code", key_code, v.code);
    chk("done", {3'b0, done}, {3'b0, v.done});
    chk("overrun", {3'b0, overrun}, {3'b0, v.ov});
    key_ack = 1'b0;
    exp_col = v.col;
    exp_kv  = v.kv;
    $display("vec %0d fila=%b ack=%b col=%b kv=%b code=%h done=%b ov=%b",
             cur_vec, v.fila, v.ack, columna, key_valid, key_code, done, overrun);
    cur_vec++;
  endtask

  task automatic check_tick(input string tag, input logic [3:0] col, input logic kv);
    chk("columna", columna, col);
    chk("key_valid", {3'b0, key_valid}, {3'b0, kv});
    exp_col = col;
    exp_kv  = kv;
    $display("%s col=%b kv=%b code=%h", tag, columna, key_valid, key_code);
  endtask

  initial begin
    // Sweep with no key.
    add(4'b0000, 0, 4'b0010, 0, 4'h0, 0, 0);
    add(4'b0000, 0, 4'b0100, 0, 4'h0, 0, 0);
    add(4'b0000, 0, 4'b1000, 0, 4'h0, 0, 0);
    add(4'b0000, 0, 4'b0001, 0, 4'h0, 0, 0);
    add(4'b0000, 0, 4'b0010, 0, 4'h0, 0, 0);
    // Row 2 col 1: capture, two more agreeing ticks, confirm key 9.
    add(4'b0100, 0, 4'b0010, 0, 4'h0, 0, 0);
    add(4'b0100, 0, 4'b0010, 0, 4'h0, 0, 0);
    add(4'b0100, 0, 4'b0010, 1, 4'h9, 1, 0);
    add(4'b0000, 0, 4'b0010, 1, 4'h9, 0, 0);
    add(4'b0000, 0, 4'b0010, 1, 4'h9, 0, 0);
    add(4'b0000, 0, 4'b0100, 1, 4'h9, 0, 0);
    add(4'b0000, 1, 4'b1000, 0, 4'h9, 0, 0);
    // Ghost on column 0.
    add(4'b0000, 0, 4'b0001, 0, 4'h9, 0, 0);
    add(4'b0011, 0, 4'b0010, 0, 4'h9, 0, 0);
    add(4'b0000, 0, 4'b0100, 0, 4'h9, 0, 0);
    add(4'b0000, 0, 4'b1000, 0, 4'h9, 0, 0);
    add(4'b0000, 0, 4'b0001, 0, 4'h9, 0, 0);
    // Key 0 left unacked.
    add(4'b0001, 0, 4'b0001, 0, 4'h9, 0, 0);
    add(4'b0001, 0, 4'b0001, 0, 4'h9, 0, 0);
    add(4'b0001, 0, 4'b0001, 1, 4'h0, 1, 0);
    add(4'b0000, 0, 4'b0001, 1, 4'h0, 0, 0);
    add(4'b0000, 0, 4'b0001, 1, 4'h0, 0, 0);
    add(4'b0000, 0, 4'b0010, 1, 4'h0, 0, 0);
    add(4'b0000, 0, 4'b0100, 1, 4'h0, 0, 0);
    add(4'b0000, 0, 4'b1000, 1, 4'h0, 0, 0);
    // Key 15 while key 0 still pending: overrun.
    add(4'b1000, 0, 4'b1000, 1, 4'h0, 0, 0);
    add(4'b1000, 0, 4'b1000, 1, 4'h0, 0, 0);
    add(4'b1000, 0, 4'b1000, 1, 4'h0, 0, 1);
    add(4'b0000, 0, 4'b1000, 1, 4'h0, 0, 0);
    add(4'b0000, 0, 4'b1000, 1, 4'h0, 0, 0);
    add(4'b0000, 0, 4'b0001, 1, 4'h0, 0, 0);
    add(4'b0000, 0, 4'b0010, 1, 4'h0, 0, 0);
    add(4'b0000, 0, 4'b0100, 1, 4'h0, 0, 0);
    add(4'b0000, 0, 4'b1000, 1, 4'h0, 0, 0);
    // Key 15 again with ack in the confirm cycle.
    add(4'b1000, 0, 4'b1000, 1, 4'h0, 0, 0);
    add(4'b1000, 0, 4'b1000, 1, 4'h0, 0, 0);
    add(4'b1000, 1, 4'b1000, 1, 4'hF, 1, 0);
    add(4'b0000, 0, 4'b1000, 1, 4'hF, 0, 0);
    add(4'b0000, 0, 4'b1000, 1, 4'hF, 0, 0);
    add(4'b0000, 0, 4'b0001, 1, 4'hF, 0, 0);
    add(4'b0000, 1, 4'b0010, 0, 4'hF, 0, 0);
    // Ack with nothing pending is ignored.
    add(4'b0000, 1, 4'b0100, 0, 4'hF, 0, 0);

    reset   = 1'b1;
    fila    = 4'b0000;
    key_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_columna", columna, 4'b0001);
    chk("rst_key_code", key_code, 4'h0);
    chk("rst_flags", {1'b0, key_valid, done, overrun}, 4'h0);
    reset   = 1'b0;
    exp_col = 4'b0001;
    exp_kv  = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Bounce: capture on column 2, then rows toggle every 3 clocks.
    run_vec('{fila: 4'b0100, ack: 1'b0, col: 4'b0100, kv: 1'b0, code: 4'hF, done: 1'b0, ov: 1'b0});
    for (int c = 0; c < 12; c++) begin
      fila = (c < 8 && ((c / 3) % 2 == 0)) ? 4'b0100 : 4'b0000;
      @(posedge clk); #1;
      chk("bounce_no_done", {3'b0, done}, 4'h0);
      if (c == 3)  check_tick("bounce tick1", 4'b0100, 1'b0);
      if (c == 7)  check_tick("bounce tick2", 4'b1000, 1'b0);
      if (c == 11) check_tick("bounce tick3", 4'b0001, 1'b0);
    end

    // Async reset mid-cycle while debouncing key 0.
    run_vec('{fila: 4'b0001, ack: 1'b0, col: 4'b0001, kv: 1'b0, code: 4'hF, done: 1'b0, ov: 1'b0});
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("arst_columna", columna, 4'b0001);
    chk("arst_key_code", key_code, 4'h0);
    chk("arst_flags", {1'b0, key_valid, done, overrun}, 4'h0);
    $display("async reset col=%b kv=%b code=%h", columna, key_valid, key_code);
    @(posedge clk); #1;
    reset   = 1'b0;
    exp_col = 4'b0001;
    exp_kv  = 1'b0;
    // A fresh debounce needs the full three ticks.
    run_vec('{fila: 4'b0001, ack: 1'b0, col: 4'b0001, kv: 1'b0, code: 4'h0, done: 1'b0, ov: 1'b0});
    run_vec('{fila: 4'b0001, ack: 1'b0, col: 4'b0001, kv: 1'b0, code: 4'h0, done: 1'b0, ov: 1'b0});
    run_vec('{fila: 4'b0001, ack: 1'b0, col: 4'b0001, kv: 1'b1, code: 4'h0, done: 1'b1, ov: 1'b0});
    run_vec('{fila: 4'b0000, ack: 1'b0, col: 4'b0001, kv: 1'b1, code: 4'h0, done: 1'b0, ov: 1'b0});
    run_vec('{fila: 4'b0000, ack: 1'b0, col: 4'b0001, kv: 1'b1, code: 4'h0, done: 1'b0, ov: 1'b0});
    run_vec('{fila: 4'b0000, ack: 1'b0, col: 4'b0010, kv: 1'b1, code: 4'h0, done: 1'b0, ov: 1'b0});
    run_vec('{fila: 4'b0000, ack: 1'b1, col: 4'b0100, kv: 1'b0, code: 4'h0, done: 1'b0, ov: 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
